// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA line renderer blocks.
//   H_ACTIVE / V_ACTIVE : active picture size in pixels
//   MODE_*              : encodings of the 2-bit motion mode input
//   motion_state_t      : states of the line position machine
//   COLOR_FULL/NONE     : 10-bit colour channel extremes
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_WRAP   = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic [1:0] {
    S_INC,
    S_DEC,
    S_HOLD_HI,
    S_HOLD_LO
  } motion_state_t;

  localparam logic [9:0] COLOR_FULL = 10'h3FF;
  localparam logic [9:0] COLOR_NONE = 10'h000;

endpackage

// File: rtl/line_motion_gen_if.sv
// ---------------------------------------------------------------------------
// line_motion_gen_if
// Pixel-side bundle between the sync/timing generator, the line renderer and
// the DAC.
//   xPos, yPos  : current pixel column / row
//   frame_tick  : one-cycle pulse per frame (start of vertical blank)
//   mode        : motion mode (static / bounce / wrap / off)
//   red, green, blue : registered pixel colour
//   line_pos    : current leading pixel of the line
// master = timing/consumer side, slave = renderer.
// ---------------------------------------------------------------------------
interface line_motion_gen_if;

  logic [9:0] xPos;
  logic [9:0] yPos;
  logic       frame_tick;
  logic [1:0] mode;
  logic [9:0] red;
  logic [9:0] green;
  logic [9:0] blue;
  logic [9:0] line_pos;

  modport master (
    output xPos, yPos, frame_tick, mode,
    input  red, green, blue, line_pos
  );

  modport slave (
    input  xPos, yPos, frame_tick, mode,
    output red, green, blue, line_pos
  );

endinterface

// File: rtl/line_pos_fsm.sv
// ---------------------------------------------------------------------------
// line_pos_fsm
// Keeps the line position, motion state and edge-hold counter. Everything
// moves only on a frame_tick edge, so a frame is always drawn with one
// consistent position.
//   vga_clk    : pixel clock
//   RST        : synchronous active-low reset
//   frame_tick : one-cycle pulse per frame
//   mode       : motion mode, only looked at on frame_tick edges
//   line_pos   : current leading pixel of the line
// ---------------------------------------------------------------------------
module line_pos_fsm
  import vga_pkg::*;
#(
  parameter int SPAN         = H_ACTIVE,
  parameter int LINE_W       = 10,
  parameter int START_POS    = 315,
  parameter int STEP         = 2,
  parameter int PAUSE_FRAMES = 30
) (
  input  logic       vga_clk,
  input  logic       RST,
  input  logic       frame_tick,
  input  logic [1:0] mode,
  output logic [9:0] line_pos
);

  // Position arithmetic is one bit wider so pos+STEP can never wrap silently.
  localparam logic [10:0] MAX_POS   = 11'(SPAN - LINE_W);
  localparam logic [10:0] STEP_EXT  = 11'(STEP);
  localparam logic [9:0]  START_VAL = 10'(START_POS);
  localparam bit          NO_PAUSE  = (PAUSE_FRAMES == 0);

  // The hold counter only ever needs to reach PAUSE_FRAMES-1.
  localparam int HOLD_W = (PAUSE_FRAMES > 2) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((PAUSE_FRAMES > 0) ? PAUSE_FRAMES - 1 : 0);

  motion_state_t     state;
  motion_state_t     state_nxt;
  logic [9:0]        pos_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [10:0]       pos_up;

  always_ff @(posedge vga_clk) begin
    if (!RST) begin
      state    <= S_INC;
      line_pos <= START_VAL;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      line_pos <= pos_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = line_pos;
    hold_nxt  = hold_cnt;
    pos_up    = {1'b0, line_pos} + STEP_EXT;

    if (frame_tick) begin
      case (mode)
        MODE_STATIC: begin
          pos_nxt   = START_VAL;
          state_nxt = S_INC;
          hold_nxt  = '0;
        end
        MODE_WRAP: begin
          pos_nxt   = (pos_up > MAX_POS) ? 10'd0 : pos_up[9:0];
          state_nxt = S_INC;
        end
        MODE_BOUNCE: begin
          case (state)
            S_INC: begin
              // Clamp onto the far edge rather than overshooting it.
              if (pos_up >= MAX_POS) begin
                pos_nxt   = MAX_POS[9:0];
                state_nxt = NO_PAUSE ? S_DEC : S_HOLD_HI;
              end else begin
                pos_nxt = pos_up[9:0];
              end
            end
            S_DEC: begin
              if ({1'b0, line_pos} <= STEP_EXT) begin
                pos_nxt   = 10'd0;
                state_nxt = NO_PAUSE ? S_INC : S_HOLD_LO;
              end else begin
                pos_nxt = line_pos - STEP_EXT[9:0];
              end
            end
            S_HOLD_HI: begin
              if (hold_cnt == HOLD_LAST) begin
                hold_nxt  = '0;
                state_nxt = S_DEC;
              end else begin
                hold_nxt = hold_cnt + HOLD_W'(1);
              end
            end
            S_HOLD_LO: begin
              if (hold_cnt == HOLD_LAST) begin
                hold_nxt  = '0;
                state_nxt = S_INC;
              end else begin
                hold_nxt = hold_cnt + HOLD_W'(1);
              end
            end
            default: state_nxt = S_INC;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/line_motion_gen.sv
// ---------------------------------------------------------------------------
// line_motion_gen
// Draws one vertical (VERTICAL=1, compares xPos) or horizontal (compares
// yPos) line of LINE_W pixels over a background. The colour output is
// registered: the colour after edge N belongs to the coordinate at edge N.
//   vga_clk : pixel clock
//   RST     : synchronous active-low reset (colour 0, line at START_POS)
//   bus     : pixel bundle (coordinates, frame_tick, mode in; rgb, line_pos out)
// ---------------------------------------------------------------------------
module line_motion_gen
  import vga_pkg::*;
#(
  parameter bit         VERTICAL     = 1'b1,
  parameter int         SPAN         = H_ACTIVE,
  parameter int         LINE_W       = 10,
  parameter int         START_POS    = 315,
  parameter int         STEP         = 2,
  parameter int         PAUSE_FRAMES = 30,
  parameter logic [9:0] FG_R         = COLOR_FULL,
  parameter logic [9:0] FG_G         = COLOR_FULL,
  parameter logic [9:0] FG_B         = COLOR_FULL,
  parameter logic [9:0] BG_R         = COLOR_NONE,
  parameter logic [9:0] BG_G         = COLOR_NONE,
  parameter logic [9:0] BG_B         = COLOR_NONE
) (
  input logic              vga_clk,
  input logic              RST,
  line_motion_gen_if.slave bus
);

  localparam logic [10:0] LINE_W_EXT = 11'(LINE_W);

  logic [9:0] line_pos;
  logic [9:0] coord;
  logic       hit;

  line_pos_fsm #(
    .SPAN         (SPAN),
    .LINE_W       (LINE_W),
    .START_POS    (START_POS),
    .STEP         (STEP),
    .PAUSE_FRAMES (PAUSE_FRAMES)
  ) u_pos_fsm (
    .vga_clk    (vga_clk),
    .RST        (RST),
    .frame_tick (bus.frame_tick),
    .mode       (bus.mode),
    .line_pos   (line_pos)
  );

  assign bus.line_pos = line_pos;

  // Upper bound is computed 11 bits wide so a line touching column 1023
  // cannot wrap around to a small value.
  always_comb begin
    coord = VERTICAL ? bus.xPos : bus.yPos;
    hit   = (coord >= line_pos) &&
            ({1'b0, coord} < ({1'b0, line_pos} + LINE_W_EXT));
  end

  always_ff @(posedge vga_clk) begin
    if (!RST) begin
      bus.red   <= '0;
      bus.green <= '0;
      bus.blue  <= '0;
    end else if (bus.mode == MODE_OFF || !hit) begin
      bus.red   <= BG_R;
      bus.green <= BG_G;
      bus.blue  <= BG_B;
    end else begin
      bus.red   <= FG_R;
      bus.green <= FG_G;
      bus.blue  <= FG_B;
    end
  end

endmodule
